// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: the bundle of signals that connects the PSRAM arbiter to its
// two requesters (video fetch, CPU) and to the PSRAM controller.
//   video : vid_req_i, vid_addr_i -> vid_ack_o, vid_valid_o, vid_rdata_o
//   cpu   : cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i -> cpu_ack_o, cpu_valid_o, cpu_rdata_o
//   psram : mem_stb_o, mem_we_o, mem_addr_o, mem_din_o <-> mem_busy_i, mem_dout_i
//   status: arb_busy_o
// Signal suffixes are named from the arbiter's point of view.
// Modports: master = the arbiter, slave = requesters plus PSRAM controller.
interface psram_arbiter_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 16
);
  logic          vid_req_i;
  logic [AW-1:0] vid_addr_i;
  logic          vid_ack_o;
  logic          vid_valid_o;
  logic [DW-1:0] vid_rdata_o;

  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_ack_o;
  logic          cpu_valid_o;
  logic [DW-1:0] cpu_rdata_o;

  logic          mem_stb_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o;
  logic          mem_busy_i;
  logic [DW-1:0] mem_dout_i;

  logic          arb_busy_o;

  modport master (
    input  vid_req_i, vid_addr_i,
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  mem_busy_i, mem_dout_i,
    output vid_ack_o, vid_valid_o, vid_rdata_o,
    output cpu_ack_o, cpu_valid_o, cpu_rdata_o,
    output mem_stb_o, mem_we_o, mem_addr_o, mem_din_o,
    output arb_busy_o
  );

  modport slave (
    output vid_req_i, vid_addr_i,
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output mem_busy_i, mem_dout_i,
    input  vid_ack_o, vid_valid_o, vid_rdata_o,
    input  cpu_ack_o, cpu_valid_o, cpu_rdata_o,
    input  mem_stb_o, mem_we_o, mem_addr_o, mem_din_o,
    input  arb_busy_o
  );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port arbiter (video fetch, CPU) in front of a single PSRAM
// controller. One transaction is outstanding at a time.
//   clk_100mhz : system clock, rising edge
//   rstn_i     : asynchronous active-low reset
//   bus        : psram_arbiter_if.master (requester, PSRAM and status signals)
// Flow: IDLE arbitrates when the controller is not busy. ISSUE holds the strobe until
// busy is seen. WAIT_DONE waits for busy to fall, then captures read data and pulses valid.
// Video has priority. Define PSRAM_ARB_ANTISTARVE_EN to force a CPU grant after
// STARVE_LIMIT consecutive video grants that happened while the CPU was waiting.
module psram_arbiter #(
  parameter int unsigned AW           = 24,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clk_100mhz,
  input  logic            rstn_i,
  psram_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e        state_q;
  logic          owner_cpu_q;
  logic          wr_q;         // survives mem_we_q clearing after ISSUE
  logic          vid_ack_q, vid_valid_q, cpu_ack_q, cpu_valid_q;
  logic          mem_stb_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q, vid_rdata_q, cpu_rdata_q;
  logic          starved;
  logic          grant_vid, grant_cpu;

`ifdef PSRAM_ARB_ANTISTARVE_EN
  localparam int unsigned     CntW  = $clog2(STARVE_LIMIT + 2);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q;

  assign starved = (starve_q == Limit);

  // Counts video grants taken while the CPU was waiting; saturates at Limit.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
    end else if (state_q == StIdle && !bus.mem_busy_i) begin
      if (grant_cpu) begin
        starve_q <= '0;
      end else if (grant_vid) begin
        if (!bus.cpu_req_i) begin
          starve_q <= '0;
        end else if (!starved) begin
          starve_q <= starve_q + CntW'(1);
        end
      end
    end
  end
`else
  logic unused_starve_limit;

  assign starved             = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  assign grant_vid = bus.vid_req_i && !(starved && bus.cpu_req_i);
  assign grant_cpu = bus.cpu_req_i && !grant_vid;

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      owner_cpu_q <= 1'b0;
      wr_q        <= 1'b0;
      vid_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_valid_q <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      // ack/valid are single-cycle pulses
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy while idle also covers PSRAM power-up
          if (!bus.mem_busy_i && (grant_vid || grant_cpu)) begin
            state_q     <= StIssue;
            mem_stb_q   <= 1'b1;
            owner_cpu_q <= grant_cpu;
            if (grant_cpu) begin
              mem_addr_q <= bus.cpu_addr_i;
              mem_din_q  <= bus.cpu_wdata_i;
              mem_we_q   <= bus.cpu_we_i;
              wr_q       <= bus.cpu_we_i;
              cpu_ack_q  <= 1'b1;
            end else begin
              mem_addr_q <= bus.vid_addr_i;
              mem_we_q   <= 1'b0;
              wr_q       <= 1'b0;
              vid_ack_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (bus.mem_busy_i) begin
            state_q   <= StWaitDone;
            mem_stb_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        StWaitDone: begin
          if (!bus.mem_busy_i) begin
            state_q <= StIdle;
            if (owner_cpu_q) begin
              cpu_valid_q <= 1'b1;
              if (!wr_q) begin
                cpu_rdata_q <= bus.mem_dout_i;
              end
            end else begin
              vid_valid_q <= 1'b1;
              vid_rdata_q <= bus.mem_dout_i;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.vid_ack_o   = vid_ack_q;
  assign bus.vid_valid_o = vid_valid_q;
  assign bus.vid_rdata_o = vid_rdata_q;
  assign bus.cpu_ack_o   = cpu_ack_q;
  assign bus.cpu_valid_o = cpu_valid_q;
  assign bus.cpu_rdata_o = cpu_rdata_q;
  assign bus.mem_stb_o   = mem_stb_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_din_o   = mem_din_q;
  assign bus.arb_busy_o  = (state_q != StIdle);

endmodule
